// File: rtl/i2c_master_reader.sv
// i2c_master_reader
//   I2C master performing one 16-bit register read per request:
//   START, {dev,W}, reg, repeated START, {dev,R}, MSB (master ACK),
//   LSB (master NACK), STOP. Every bus symbol is four quarter-ticks
//   P0..P3: SCL is low in P0/P3 and high in P1/P2. Data changes in P0
//   and SDA is sampled at the end of P2.
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start             request pulse, honoured only while idle
//   dev_addr/reg_addr 7-bit slave address / register index, latched on accept
//   scl               push-pull SCL
//   sda_oe            1 = pull SDA low, 0 = release (open drain)
//   sda_i             SDA pin, double-flopped internally
//   busy              high from accept until done
//   done              one-cycle completion pulse
//   ack_err           with done: 1 if the slave NACKed
//   rd_data           last successfully read value, MSB first on the bus
module i2c_master_reader #(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic [15:0] rd_data
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WADDR, S_ACK1, S_WREG, S_ACK2, S_RSTART, S_RADDR,
    S_ACK3, S_RMSB, S_MACK, S_RLSB, S_MNACK, S_STOP, S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      phase;
  logic [2:0]      bit_cnt;
  logic [CW-1:0]   div_cnt;
  logic            qtick;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q;
  logic [7:0]      addr_w;
  logic [7:0]      addr_r;
  logic [15:0]     rx;
  logic            nack;
  logic            sda_m;
  logic            sda_s;
  logic            tx_bit;
  logic            scl_c;
  logic            oe_c;
  logic            byte_st;
  logic            ack_st;

  assign qtick   = busy && (div_cnt == CW'(CLK_DIV - 1));
  assign addr_w  = {dev_q, 1'b0};
  assign addr_r  = {dev_q, 1'b1};
  assign byte_st = (state == S_WADDR) || (state == S_WREG) || (state == S_RADDR) ||
                   (state == S_RMSB)  || (state == S_RLSB);
  assign ack_st  = (state == S_ACK1) || (state == S_ACK2) || (state == S_ACK3);

  always_comb begin
    tx_bit = 1'b1;
    case (state)
      S_WADDR: tx_bit = addr_w[bit_cnt];
      S_WREG:  tx_bit = reg_q[bit_cnt];
      S_RADDR: tx_bit = addr_r[bit_cnt];
      default: tx_bit = 1'b1;
    endcase
  end

  // Bus levels for the current symbol/phase; registered below so scl and
  // sda_oe always move on the same clock edge.
  always_comb begin
    scl_c = (phase == 2'd1) || (phase == 2'd2);
    oe_c  = 1'b0;
    case (state)
      S_IDLE, S_DONE:          scl_c = 1'b1;
      S_START, S_RSTART:       oe_c  = phase[1];          // SDA falls at P2 while SCL high
      S_WADDR, S_WREG, S_RADDR: oe_c = ~tx_bit;
      S_MACK:                  oe_c  = 1'b1;
      S_STOP: begin
        scl_c = (phase != 2'd0);                          // SCL stays high after P1
        oe_c  = ~phase[1];                                // SDA rises at P2 while SCL high
      end
      default:                 oe_c  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= 2'd0;
      bit_cnt <= 3'd7;
      div_cnt <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      rx      <= '0;
      nack    <= 1'b0;
      sda_m   <= 1'b1;
      sda_s   <= 1'b1;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rd_data <= '0;
    end else begin
      sda_m  <= sda_i;
      sda_s  <= sda_m;
      scl    <= scl_c;
      sda_oe <= oe_c;
      done   <= 1'b0;
      if (busy) div_cnt <= qtick ? '0 : div_cnt + CW'(1);
      case (state)
        S_IDLE: begin
          // A start coinciding with the done pulse is not taken.
          if (start && !done) begin
            state   <= S_START;
            busy    <= 1'b1;
            div_cnt <= '0;
            phase   <= 2'd0;
            bit_cnt <= 3'd7;
            dev_q   <= dev_addr;
            reg_q   <= reg_addr;
            nack    <= 1'b0;
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          ack_err <= nack;
          if (!nack) rd_data <= rx;
          state   <= S_IDLE;
        end
        default: begin
          if (qtick) begin
            phase <= phase + 2'd1;
            if (phase == 2'd2) begin
              if (ack_st) nack <= nack | sda_s;
              if ((state == S_RMSB) || (state == S_RLSB)) rx <= {rx[14:0], sda_s};
            end
            if (phase == 2'd3) begin
              bit_cnt <= byte_st ? bit_cnt - 3'd1 : 3'd7;
              case (state)
                S_START:  state <= S_WADDR;
                S_WADDR:  if (bit_cnt == 3'd0) state <= S_ACK1;
                S_ACK1:   state <= nack ? S_STOP : S_WREG;
                S_WREG:   if (bit_cnt == 3'd0) state <= S_ACK2;
                S_ACK2:   state <= nack ? S_STOP : S_RSTART;
                S_RSTART: state <= S_RADDR;
                S_RADDR:  if (bit_cnt == 3'd0) state <= S_ACK3;
                S_ACK3:   state <= nack ? S_STOP : S_RMSB;
                S_RMSB:   if (bit_cnt == 3'd0) state <= S_MACK;
                S_MACK:   state <= S_RLSB;
                S_RLSB:   if (bit_cnt == 3'd0) state <= S_MNACK;
                S_MNACK:  state <= S_STOP;
                S_STOP:   state <= S_DONE;
                default:  state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_reader.sv
// tb_i2c_master_reader
//   Drives i2c_master_reader (CLK_DIV=4) against a behavioural I2C slave
//   that answers at four addresses with fixed 16-bit readings. Expected
//   {ack_err, rd_data} records are queued when a request is issued and
//   compared against what the DUT reports on done. A bus monitor counts
//   START/STOP conditions (SDA moving while SCL stays high).
module tb_i2c_master_reader;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  dev_addr = '0;
  logic [7:0]  reg_addr = '0;
  logic        scl;
  logic        sda_oe;
  logic        sda_bus;
  logic        busy;
  logic        done;
  logic        ack_err;
  logic [15:0] rd_data;

  i2c_master_reader #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .scl(scl), .sda_oe(sda_oe), .sda_i(sda_bus), .busy(busy), .done(done),
    .ack_err(ack_err), .rd_data(rd_data)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- open-drain bus + slave model ----------------
  logic s_oe = 1'b0;
  assign sda_bus = (sda_oe || s_oe) ? 1'b0 : 1'b1;

  typedef enum {SL_IDLE, SL_ADDR, SL_WREG, SL_IGNW, SL_TX, SL_IGN} sl_t;
  sl_t         sl_st = SL_IDLE;
  int          s_cnt = 0;
  int          s_tpos = 0;
  logic [7:0]  s_sh = '0;
  logic [15:0] s_val = '0;
  logic [7:0]  s_reg = '0;
  logic [16:0] s_lk;
  logic        s_mack_ok = 1'b0;
  logic        s_mnack_ok = 1'b0;
  logic        p_scl = 1'b1;
  logic        p_sda = 1'b1;

  function automatic logic [16:0] lookup(input logic [6:0] a);
    case (a)
      7'h44:   return {1'b1, 16'd250};
      7'h5A:   return {1'b1, 16'd600};
      7'h5C:   return {1'b1, 16'd1013};
      7'h23:   return {1'b1, 16'd350};
      default: return 17'd0;
    endcase
  endfunction

  always @(scl or sda_bus or rst) begin
    if (rst) begin
      sl_st = SL_IDLE;
      s_oe  = 1'b0;
    end else if (scl && p_scl) begin
      if (p_sda && !sda_bus) begin
        sl_st = SL_ADDR; s_cnt = 0; s_oe = 1'b0;
      end else if (!p_sda && sda_bus) begin
        sl_st = SL_IDLE; s_oe = 1'b0;
      end
    end else if (scl && !p_scl) begin
      case (sl_st)
        SL_ADDR, SL_WREG: begin
          if (s_cnt < 8) s_sh = {s_sh[6:0], sda_bus};
          s_cnt++;
        end
        SL_TX: begin
          if (s_tpos == 8)  s_mack_ok  = (sda_bus == 1'b0);
          if (s_tpos == 17) s_mnack_ok = (sda_bus == 1'b1);
          s_tpos++;
        end
        default: ;
      endcase
    end else if (!scl && p_scl) begin
      case (sl_st)
        SL_ADDR: begin
          if (s_cnt == 8) begin
            s_lk = lookup(s_sh[7:1]);
            if (s_lk[16]) begin s_oe = 1'b1; s_val = s_lk[15:0]; end
            else sl_st = SL_IGN;
          end else if (s_cnt == 9) begin
            s_oe = 1'b0;
            if (s_sh[0]) begin sl_st = SL_TX; s_tpos = 0; s_oe = ~s_val[15]; end
            else begin sl_st = SL_WREG; s_cnt = 0; end
          end
        end
        SL_WREG: begin
          if (s_cnt == 8) begin s_oe = 1'b1; s_reg = s_sh; end
          else if (s_cnt == 9) begin s_oe = 1'b0; sl_st = SL_IGNW; end
        end
        SL_TX: begin
          if (s_tpos < 8)        s_oe = ~s_val[15 - s_tpos];
          else if (s_tpos == 8)  s_oe = 1'b0;
          else if (s_tpos <= 16) s_oe = ~s_val[16 - s_tpos];
          else                   s_oe = 1'b0;
        end
        default: ;
      endcase
    end
    p_scl = scl;
    p_sda = sda_bus;
  end

  // ---------------- bus monitor + result capture ----------------
  int          n_start = 0;
  int          n_stop = 0;
  int          done_cnt = 0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && m_scl && scl) begin
      if (m_sda && !sda_bus)      n_start++;
      else if (!m_sda && sda_bus) n_stop++;
    end
    m_scl = scl;
    m_sda = sda_bus;
    if (done) begin
      done_cnt++;
      got_q.push_back({ack_err, rd_data});
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One full request. poke_at > 0 raises start for one cycle that many
  // cycles into the transaction; it must be ignored.
  task automatic run_read(input logic [6:0] dev, input logic [7:0] rg,
                          input logic exp_nack, input logic [15:0] exp_data,
                          input int poke_at);
    int base_s, base_p, base_d, t0, n, lat_exp;
    logic seen;
    logic [16:0] g, e;
    base_s  = n_start;
    base_p  = n_stop;
    base_d  = done_cnt;
    lat_exp = (exp_nack ? 11 : 48) * 4 * DIV + 1;
    @(negedge clk);
    dev_addr = dev;
    reg_addr = rg;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    exp_q.push_back({exp_nack, exp_data});
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    dev_addr = 7'($urandom_range(0, 127));
    reg_addr = 8'($urandom_range(0, 255));
    n = 0;
    seen = 1'b0;
    while (n < 3000 && !seen) begin
      @(negedge clk);
      n++;
      start = (poke_at > 0 && n == poke_at);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      chk("latency", cyc - t0, lat_exp);
      chk("busy_with_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("done_width", {31'd0, done}, 32'd0);
    end
    repeat (40) @(negedge clk);
    chk("idle_scl", {31'd0, scl}, 32'd1);
    chk("idle_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("done_count", done_cnt - base_d, 32'd1);
    chk("start_conds", n_start - base_s, exp_nack ? 32'd1 : 32'd2);
    chk("stop_conds", n_stop - base_p, 32'd1);
    if (!exp_nack) begin
      chk("slave_reg", {24'd0, s_reg}, {24'd0, rg});
      chk("master_ack", {31'd0, s_mack_ok}, 32'd1);
      chk("master_nack", {31'd0, s_mnack_ok}, 32'd1);
    end
    e = exp_q.pop_front();
    if (got_q.size() == 0) begin
      chk("result_present", 32'd0, 32'd1);
    end else begin
      g = got_q.pop_front();
      chk("ack_err", {31'd0, g[16]}, {31'd0, e[16]});
      chk("rd_data", {16'd0, g[15:0]}, {16'd0, e[15:0]});
    end
  endtask

  typedef struct {
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic        nack;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] last_good;
    int base_d;

    vecs[0] = '{dev: 7'h44, rg: 8'h00, nack: 1'b0, data: 16'd250};
    vecs[1] = '{dev: 7'h5A, rg: 8'h01, nack: 1'b0, data: 16'd600};
    vecs[2] = '{dev: 7'h5C, rg: 8'h02, nack: 1'b0, data: 16'd1013};
    vecs[3] = '{dev: 7'h23, rg: 8'h03, nack: 1'b0, data: 16'd350};
    vecs[4] = '{dev: 7'h10, rg: 8'h04, nack: 1'b1, data: 16'd0};
    last_good = 16'd0;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].nack) vecs[i].data = last_good;
      else last_good = vecs[i].data;
    end

    // reset held three cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // table of reads, including the NACK case that must hold rd_data
    for (int i = 0; i < 5; i++)
      run_read(vecs[i].dev, vecs[i].rg, vecs[i].nack, vecs[i].data, 0);
    chk("hold_after_nack", {16'd0, rd_data}, {16'd0, last_good});

    // start pulse mid-transaction is ignored
    run_read(7'h44, 8'h05, 1'b0, 16'd250, 50);

    // reset 300 cycles into a read
    base_d = done_cnt;
    @(negedge clk);
    dev_addr = 7'h44;
    reg_addr = 8'h00;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_scl", {31'd0, scl}, 32'd1);
    chk("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    chk("no_done_after_rst", done_cnt - base_d, 32'd0);
    chk("rd_data_after_rst", {16'd0, rd_data}, 32'd0);
    got_q.delete();

    run_read(7'h5A, 8'h06, 1'b0, 16'd600, 0);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
